bp_be_dual_issue_ctrl: RTL and testbench

//  Issue-slot controller for the dual-issue scheduler. Each cycle it decides whether the

---
 rtl/bp_be_dual_issue_ctrl.sv | 127 ++++++++++++
 tb/tb_bp_be_dual_issue_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_be_dual_issue_ctrl.sv
// Dual-issue slot controller: pair hazard checks, shared-unit limits,
// serializing drain/solo sequencing and a saturating dual-issue counter.
module bp_be_dual_issue_ctrl #(
  parameter bit enable_dual_p = 1'b1,
  parameter int mem_ports_p   = 1,
  parameter int long_ports_p  = 1,
  parameter int cnt_width_p   = 32
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   slot0_v_i,
  input  logic                   slot0_mem_v_i,
  input  logic                   slot0_long_v_i,
  input  logic                   slot0_csr_v_i,
  input  logic                   slot0_fence_v_i,
  input  logic                   slot0_iwb_v_i,
  input  logic                   slot0_fwb_v_i,
  input  logic [4:0]             slot0_rd_addr_i,
  input  logic                   slot1_v_i,
  input  logic                   slot1_mem_v_i,
  input  logic                   slot1_long_v_i,
  input  logic                   slot1_csr_v_i,
  input  logic                   slot1_fence_v_i,
  input  logic                   slot1_irs1_v_i,
  input  logic                   slot1_irs2_v_i,
  input  logic                   slot1_frs1_v_i,
  input  logic                   slot1_frs2_v_i,
  input  logic                   slot1_frs3_v_i,
  input  logic [4:0]             slot1_rs1_addr_i,
  input  logic [4:0]             slot1_rs2_addr_i,
  input  logic [4:0]             slot1_rs3_addr_i,
  input  logic                   slot1_iwb_v_i,
  input  logic                   slot1_fwb_v_i,
  input  logic [4:0]             slot1_rd_addr_i,
  input  logic                   dispatch_ready_i,
  input  logic                   pipe_empty_i,
  input  logic                   suppress_i,
  output logic                   issue0_o,
  output logic                   issue1_o,
  output logic [1:0]             state_o,
  output logic [cnt_width_p-1:0] dual_count_o
);

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] SOLO  = 2'd2;

  logic [1:0] state_r, state_n;
  logic [cnt_width_p-1:0] cnt_r;
  logic ser0, ser1, base, issue0;
  logic rd0_nz, int_raw, fp_raw, waw;
  logic unit_clash, pair_block;

  assign ser0 = slot0_csr_v_i | slot0_fence_v_i;
  assign ser1 = slot1_csr_v_i | slot1_fence_v_i;
  assign base = slot0_v_i & dispatch_ready_i & ~suppress_i;

  assign rd0_nz = |slot0_rd_addr_i;

  assign int_raw = slot0_iwb_v_i & rd0_nz
    & ((slot1_irs1_v_i & (slot1_rs1_addr_i == slot0_rd_addr_i))
     | (slot1_irs2_v_i & (slot1_rs2_addr_i == slot0_rd_addr_i)));

  // fp x0 is a real register, so no zero exemption here
  assign fp_raw = slot0_fwb_v_i
    & ((slot1_frs1_v_i & (slot1_rs1_addr_i == slot0_rd_addr_i))
     | (slot1_frs2_v_i & (slot1_rs2_addr_i == slot0_rd_addr_i))
     | (slot1_frs3_v_i & (slot1_rs3_addr_i == slot0_rd_addr_i)));

  assign waw = (slot1_rd_addr_i == slot0_rd_addr_i)
    & ((slot0_iwb_v_i & slot1_iwb_v_i & rd0_nz)
     | (slot0_fwb_v_i & slot1_fwb_v_i));

  assign unit_clash =
      (slot0_mem_v_i & slot1_mem_v_i & (mem_ports_p == 1))
    | (slot0_long_v_i & slot1_long_v_i & (long_ports_p == 1));

  assign pair_block = int_raw | fp_raw | waw | ser1 | unit_clash;

  always_comb begin
    issue0  = 1'b0;
    state_n = state_r;
    case (state_r)
      RUN: begin
        if (!ser0) begin
          issue0 = base;
        end else if (pipe_empty_i) begin
          issue0 = base;
          if (base) state_n = SOLO;
        end else if (dispatch_ready_i) begin
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (pipe_empty_i) begin
          issue0 = base;
          if (base) state_n = SOLO;
        end
      end
      SOLO: begin
        if (pipe_empty_i) state_n = RUN;
      end
      default: state_n = RUN;
    endcase
    // a flush abandons any pending serialization
    if (suppress_i) state_n = RUN;
  end

  assign issue0_o = issue0 & reset_n_i;
  assign issue1_o = issue0_o & (state_r == RUN) & ~ser0
                  & slot1_v_i & enable_dual_p & ~pair_block;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= RUN;
      cnt_r   <= '0;
    end else begin
      state_r <= state_n;
      if (issue0_o && issue1_o && !(&cnt_r))
        cnt_r <= cnt_r + cnt_width_p'(1);
    end
  end

  assign state_o      = state_r;
  assign dual_count_o = cnt_r;

endmodule

// File: tb/tb_bp_be_dual_issue_ctrl.sv
// Bench for bp_be_dual_issue_ctrl: vector table, corner sequences,
// and randomized traffic checked against a rule-level model.
module tb_bp_be_dual_issue_ctrl;

  typedef struct {
    logic v0, mem0, long0, csr0, fence0, iwb0, fwb0;
    logic [4:0] rd0;
    logic v1, mem1, long1, csr1, fence1;
    logic irs1, irs2, frs1, frs2, frs3;
    logic [4:0] rs1, rs2, rs3;
    logic iwb1, fwb1;
    logic [4:0] rd1;
    logic rdy, pe, sup;
  } stim_t;

  typedef struct {
    stim_t s;
    logic e0, e1, e1_m2;
    string name;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n_i = 1'b0;
  logic v0, mem0, long0, csr0, fence0, iwb0, fwb0;
  logic [4:0] rd0;
  logic v1, mem1, long1, csr1, fence1;
  logic irs1, irs2, frs1, frs2, frs3;
  logic [4:0] rs1, rs2, rs3;
  logic iwb1, fwb1;
  logic [4:0] rd1;
  logic rdy, pe, sup;

  logic i0_a, i1_a, i0_m, i1_m, i0_c, i1_c, i0_s, i1_s;
  logic [1:0] st_a, st_m, st_c, st_s;
  logic [31:0] cnt_a, cnt_m, cnt_s;
  logic [3:0] cnt_c;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

`define DUT_PORTS(I0, I1, ST, CNT) \
    .clk_i(clk), .reset_n_i(reset_n_i), \
    .slot0_v_i(v0), .slot0_mem_v_i(mem0), .slot0_long_v_i(long0), \
    .slot0_csr_v_i(csr0), .slot0_fence_v_i(fence0), \
    .slot0_iwb_v_i(iwb0), .slot0_fwb_v_i(fwb0), .slot0_rd_addr_i(rd0), \
    .slot1_v_i(v1), .slot1_mem_v_i(mem1), .slot1_long_v_i(long1), \
    .slot1_csr_v_i(csr1), .slot1_fence_v_i(fence1), \
    .slot1_irs1_v_i(irs1), .slot1_irs2_v_i(irs2), \
    .slot1_frs1_v_i(frs1), .slot1_frs2_v_i(frs2), .slot1_frs3_v_i(frs3), \
    .slot1_rs1_addr_i(rs1), .slot1_rs2_addr_i(rs2), .slot1_rs3_addr_i(rs3), \
    .slot1_iwb_v_i(iwb1), .slot1_fwb_v_i(fwb1), .slot1_rd_addr_i(rd1), \
    .dispatch_ready_i(rdy), .pipe_empty_i(pe), .suppress_i(sup), \
    .issue0_o(I0), .issue1_o(I1), .state_o(ST), .dual_count_o(CNT)

  bp_be_dual_issue_ctrl dut (`DUT_PORTS(i0_a, i1_a, st_a, cnt_a));
  bp_be_dual_issue_ctrl #(.mem_ports_p(2)) dut_m2 (`DUT_PORTS(i0_m, i1_m, st_m, cnt_m));
  bp_be_dual_issue_ctrl #(.cnt_width_p(4)) dut_c4 (`DUT_PORTS(i0_c, i1_c, st_c, cnt_c));
  bp_be_dual_issue_ctrl #(.enable_dual_p(1'b0)) dut_sd (`DUT_PORTS(i0_s, i1_s, st_s, cnt_s));

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(stim_t s);
    v0 = s.v0; mem0 = s.mem0; long0 = s.long0; csr0 = s.csr0;
    fence0 = s.fence0; iwb0 = s.iwb0; fwb0 = s.fwb0; rd0 = s.rd0;
    v1 = s.v1; mem1 = s.mem1; long1 = s.long1; csr1 = s.csr1;
    fence1 = s.fence1; irs1 = s.irs1; irs2 = s.irs2;
    frs1 = s.frs1; frs2 = s.frs2; frs3 = s.frs3;
    rs1 = s.rs1; rs2 = s.rs2; rs3 = s.rs3;
    iwb1 = s.iwb1; fwb1 = s.fwb1; rd1 = s.rd1;
    rdy = s.rdy; pe = s.pe; sup = s.sup;
  endtask

  // slot0: add x5 ; slot1: add x6, x7
  function automatic stim_t add_pair();
    stim_t s;
    s = '{default: '0};
    s.v0 = 1; s.iwb0 = 1; s.rd0 = 5;
    s.v1 = 1; s.irs1 = 1; s.rs1 = 7; s.iwb1 = 1; s.rd1 = 6;
    s.rdy = 1; s.pe = 1;
    return s;
  endfunction

  function automatic stim_t rnd_stim();
    stim_t s;
    s.v0 = $urandom_range(0, 7) != 0;
    s.mem0 = $urandom_range(0, 1) == 1;
    s.long0 = $urandom_range(0, 3) == 0;
    s.csr0 = $urandom_range(0, 11) == 0;
    s.fence0 = $urandom_range(0, 15) == 0;
    s.iwb0 = $urandom_range(0, 1) == 1;
    s.fwb0 = $urandom_range(0, 3) == 0;
    s.rd0 = 5'($urandom_range(0, 3));
    s.v1 = $urandom_range(0, 5) != 0;
    s.mem1 = $urandom_range(0, 1) == 1;
    s.long1 = $urandom_range(0, 3) == 0;
    s.csr1 = $urandom_range(0, 11) == 0;
    s.fence1 = $urandom_range(0, 15) == 0;
    s.irs1 = $urandom_range(0, 1) == 1;
    s.irs2 = $urandom_range(0, 1) == 1;
    s.frs1 = $urandom_range(0, 3) == 0;
    s.frs2 = $urandom_range(0, 3) == 0;
    s.frs3 = $urandom_range(0, 5) == 0;
    s.rs1 = 5'($urandom_range(0, 3));
    s.rs2 = 5'($urandom_range(0, 3));
    s.rs3 = 5'($urandom_range(0, 3));
    s.iwb1 = $urandom_range(0, 1) == 1;
    s.fwb1 = $urandom_range(0, 3) == 0;
    s.rd1 = 5'($urandom_range(0, 3));
    s.rdy = $urandom_range(0, 6) != 0;
    s.pe = $urandom_range(0, 1) == 1;
    s.sup = $urandom_range(0, 15) == 0;
    return s;
  endfunction

  // Can slot1 legally pair with slot0, ignoring issue state?
  function automatic bit pair_ok(stim_t s, int mem_ports, int long_ports);
    logic [4:0] src [3];
    bit rd_int [3];
    bit rd_fp [3];
    bit bad = 0;
    src = '{s.rs1, s.rs2, s.rs3};
    rd_int = '{s.irs1, s.irs2, 1'b0};
    rd_fp = '{s.frs1, s.frs2, s.frs3};
    for (int k = 0; k < 3; k++) begin
      if (src[k] == s.rd0) begin
        if (rd_int[k] && s.iwb0 && s.rd0 != 0) bad = 1;
        if (rd_fp[k] && s.fwb0) bad = 1;
      end
    end
    if (s.rd0 == s.rd1) begin
      if (s.iwb0 && s.iwb1 && s.rd0 != 0) bad = 1;
      if (s.fwb0 && s.fwb1) bad = 1;
    end
    if (s.csr1 || s.fence1) bad = 1;
    if (int'(s.mem0) + int'(s.mem1) > mem_ports) bad = 1;
    if (int'(s.long0) + int'(s.long1) > long_ports) bad = 1;
    return !bad;
  endfunction

  // model modes: 0 running, 1 waiting for drain, 2 serial op alone
  int m_mode;
  int m_cnt_a, m_cnt_m, m_cnt_c;

  function automatic bit m_issue0(stim_t s, int mode);
    bit want = s.v0 && s.rdy && !s.sup;
    bit serial = s.csr0 || s.fence0;
    if (mode == 2) return 0;
    if (mode == 1) return want && s.pe;
    return serial ? (want && s.pe) : want;
  endfunction

  function automatic int m_next(stim_t s, int mode, bit did0);
    bit serial = s.csr0 || s.fence0;
    if (s.sup) return 0;
    if (mode == 2) return s.pe ? 0 : 2;
    if (mode == 1) return did0 ? 2 : 1;
    if (serial && did0) return 2;
    if (serial && !s.pe && s.rdy) return 1;
    return 0;
  endfunction

  task automatic do_reset();
    reset_n_i = 1'b0;
    @(posedge clk);
    #1;
    reset_n_i = 1'b1;
    m_mode = 0; m_cnt_a = 0; m_cnt_m = 0; m_cnt_c = 0;
  endtask

  task automatic seq_cycle(stim_t s, string nm, bit e0, bit e1, int est);
    drive(s);
    @(negedge clk);
    chk({nm, ".issue0"}, i0_a, e0);
    chk({nm, ".issue1"}, i1_a, e1);
    @(posedge clk);
    #1;
    chk({nm, ".state"}, st_a, est);
  endtask

  vec_t vec [15];

  initial begin
    stim_t s;
    bit e0, e1, e1m, ok;
    int nx;

    for (int i = 0; i < 15; i++) begin
      vec[i].s = add_pair();
      vec[i].e0 = 1; vec[i].e1 = 0; vec[i].e1_m2 = 0;
    end
    vec[0].name = "indep";
    vec[0].e1 = 1; vec[0].e1_m2 = 1;
    vec[1].name = "int_raw_rs2";
    vec[1].s.irs2 = 1; vec[1].s.rs2 = 5;
    vec[2].name = "raw_x0";
    vec[2].s.rd0 = 0; vec[2].s.irs2 = 1; vec[2].s.rs2 = 0;
    vec[2].e1 = 1; vec[2].e1_m2 = 1;
    vec[3].name = "mem_pair";
    vec[3].s.mem0 = 1; vec[3].s.mem1 = 1; vec[3].e1_m2 = 1;
    vec[4].name = "long_pair";
    vec[4].s.long0 = 1; vec[4].s.long1 = 1;
    vec[5].name = "fp_raw_rs3";
    vec[5].s.iwb0 = 0; vec[5].s.fwb0 = 1; vec[5].s.rd0 = 3;
    vec[5].s.frs3 = 1; vec[5].s.rs3 = 3;
    vec[6].name = "fp_raw_f0";
    vec[6].s.iwb0 = 0; vec[6].s.fwb0 = 1; vec[6].s.rd0 = 0;
    vec[6].s.irs1 = 0; vec[6].s.frs1 = 1; vec[6].s.rs1 = 0;
    vec[7].name = "int_waw";
    vec[7].s.rd1 = 5;
    vec[8].name = "waw_x0";
    vec[8].s.rd0 = 0; vec[8].s.rd1 = 0;
    vec[8].e1 = 1; vec[8].e1_m2 = 1;
    vec[9].name = "cross_file";
    vec[9].s.irs1 = 0; vec[9].s.frs1 = 1; vec[9].s.rs1 = 5;
    vec[9].e1 = 1; vec[9].e1_m2 = 1;
    vec[10].name = "ser1";
    vec[10].s.csr1 = 1;
    vec[11].name = "not_ready";
    vec[11].s.rdy = 0; vec[11].e0 = 0;
    vec[12].name = "suppress";
    vec[12].s.sup = 1; vec[12].e0 = 0;
    vec[13].name = "slot1_invalid";
    vec[13].s.v1 = 0;
    vec[14].name = "slot0_invalid";
    vec[14].s.v0 = 0; vec[14].e0 = 0;

    drive(add_pair());
    reset_n_i = 1'b0;
    #12;
    chk("reset.issue0", i0_a, 0);
    chk("reset.issue1", i1_a, 0);
    chk("reset.state", st_a, 0);
    chk("reset.count", cnt_a, 0);
    @(posedge clk);
    #1;
    reset_n_i = 1'b1;

    // test 1 counter step
    drive(add_pair());
    @(posedge clk);
    #1;
    chk("first_dual.count", cnt_a, 1);

    for (int i = 0; i < 15; i++) begin
      drive(vec[i].s);
      @(negedge clk);
      chk({vec[i].name, ".issue0"}, i0_a, vec[i].e0);
      chk({vec[i].name, ".issue1"}, i1_a, vec[i].e1);
      chk({vec[i].name, ".issue1_m2"}, i1_m, vec[i].e1_m2);
      chk({vec[i].name, ".issue1_sd"}, i1_s, 0);
      @(posedge clk);
      #1;
    end

    // CSR drain / solo sequence
    do_reset();
    s = add_pair();
    s.csr0 = 1; s.pe = 0;
    seq_cycle(s, "csr_wait1", 0, 0, 1);
    seq_cycle(s, "csr_wait2", 0, 0, 1);
    seq_cycle(s, "csr_wait3", 0, 0, 1);
    s.pe = 1;
    seq_cycle(s, "csr_go", 1, 0, 2);
    s.pe = 0;
    seq_cycle(s, "solo_busy", 0, 0, 2);
    s.pe = 1;
    seq_cycle(s, "solo_exit", 0, 0, 0);

    // flush while draining
    do_reset();
    s = add_pair();
    s.fence0 = 1; s.pe = 0;
    seq_cycle(s, "fence_wait", 0, 0, 1);
    s.pe = 1; s.sup = 1;
    seq_cycle(s, "drain_flush", 0, 0, 0);

    // randomized traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      s = rnd_stim();
      drive(s);
      @(negedge clk);
      e0 = m_issue0(s, m_mode);
      ok = e0 && m_mode == 0 && !(s.csr0 || s.fence0) && s.v1;
      e1 = ok && pair_ok(s, 1, 1);
      e1m = ok && pair_ok(s, 2, 1);
      chk("rnd.issue0", i0_a, e0);
      chk("rnd.issue1", i1_a, e1);
      chk("rnd.issue1_m2", i1_m, e1m);
      chk("rnd.issue1_sd", i1_s, 0);
      if (e1) begin
        m_cnt_a++;
        if (m_cnt_c < 15) m_cnt_c++;
      end
      if (e1m) m_cnt_m++;
      nx = m_next(s, m_mode, e0);
      @(posedge clk);
      #1;
      m_mode = nx;
      chk("rnd.state", st_a, m_mode);
      chk("rnd.count", cnt_a, m_cnt_a);
      chk("rnd.count_m2", cnt_m, m_cnt_m);
      chk("rnd.count_c4", cnt_c, m_cnt_c);
      chk("rnd.count_sd", cnt_s, 0);
    end

    // saturation then async reset mid-run
    do_reset();
    drive(add_pair());
    repeat (17) @(posedge clk);
    #1;
    chk("sat.count_c4", cnt_c, 15);
    chk("sat.count", cnt_a, 17);
    s = add_pair();
    s.csr0 = 1; s.pe = 0;
    drive(s);
    @(posedge clk);
    #3;
    chk("sat.drain", st_a, 1);
    reset_n_i = 1'b0;
    #1;
    chk("areset.count_c4", cnt_c, 0);
    chk("areset.count", cnt_a, 0);
    chk("areset.state", st_a, 0);
    s.csr0 = 0; s.pe = 1;
    drive(s);
    #1;
    chk("areset.issue0", i0_a, 0);
    chk("areset.issue1", i1_a, 0);
    @(negedge clk);
    reset_n_i = 1'b1;
    @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
